// File: rtl/aespim_keyexp_sequencer.sv
// Key-expansion command sequencer for the AES PIM accelerator: LD x4, NUM_ROUNDS x (KEXR, KEX x3),
// ST x4, streaming w0..w43 downstream. Define AESPIM_SEQ_ZEROIZE_EN to zero the accelerator on abort.
module aespim_keyexp_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int OP_W       = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            key_valid_i,
    output logic            key_ready_o,
    input  logic [31:0]     key_data_i,
    output logic            acc_start_o,
    output logic [OP_W-1:0] acc_op_o,
    output logic [31:0]     acc_data_o,
    output logic [3:0]      acc_rcon_idx_o,
    input  logic [31:0]     acc_data_i,
    output logic            rk_valid_o,
    input  logic            rk_ready_i,
    output logic [31:0]     rk_data_o,
    output logic [5:0]      rk_idx_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_KEXR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_KEX  = OP_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FLUSH,
        ST_DRAIN
`ifdef AESPIM_SEQ_ZEROIZE_EN
        , ST_ZERO
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  round_q, round_d;
    logic [5:0]  out_cnt_q, out_cnt_d;
    logic        rk_valid_q, rk_valid_d;
    logic [31:0] rk_data_q, rk_data_d;
    logic [5:0]  rk_idx_q, rk_idx_d;
    logic        done_q, done_d;
    logic        issue, out_free, abort_act;

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        round_d        = round_q;
        out_cnt_d      = out_cnt_q;
        rk_valid_d     = rk_valid_q && !rk_ready_i;
        rk_data_d      = rk_data_q;
        rk_idx_d       = rk_idx_q;
        done_d         = 1'b0;
        issue          = 1'b0;
        key_ready_o    = 1'b0;
        acc_start_o    = 1'b0;
        acc_op_o       = OP_LD;
        acc_data_o     = '0;
        acc_rcon_idx_o = '0;
        // The output register may be refilled in the same cycle it is accepted.
        out_free       = !rk_valid_q || rk_ready_i;
        abort_act      = abort_i && (state_q != ST_IDLE);
`ifdef AESPIM_SEQ_ZEROIZE_EN
        if (state_q == ST_ZERO) abort_act = 1'b0;
`endif

        if (abort_act) begin
            rk_valid_d = 1'b0;
`ifdef AESPIM_SEQ_ZEROIZE_EN
            state_d    = ST_ZERO;
            word_cnt_d = '0;
`else
            state_d    = ST_IDLE;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d    = ST_LOAD;
                        word_cnt_d = '0;
                        round_d    = 4'd1;
                        out_cnt_d  = '0;
                    end
                end
                ST_LOAD: begin
                    key_ready_o = 1'b1;
                    if (key_valid_i) begin
                        acc_start_o = 1'b1;
                        acc_data_o  = key_data_i;
                        word_cnt_d  = word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd3) state_d = ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (out_free) begin
                        issue       = 1'b1;
                        acc_start_o = 1'b1;
                        word_cnt_d  = word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd0) begin
                            acc_op_o       = OP_KEXR;
                            acc_rcon_idx_o = round_q - 4'd1;
                        end else begin
                            acc_op_o = OP_KEX;
                        end
                        if (word_cnt_q == 2'd3) begin
                            if (round_q == 4'(NUM_ROUNDS)) state_d = ST_FLUSH;
                            else round_d = round_q + 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // ST shifts zeros in while the last four round-key words fall out of word 0.
                    if (out_free) begin
                        issue       = 1'b1;
                        acc_start_o = 1'b1;
                        acc_op_o    = OP_ST;
                        word_cnt_d  = word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd3) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rk_valid_q && rk_ready_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`ifdef AESPIM_SEQ_ZEROIZE_EN
                ST_ZERO: begin
                    acc_start_o = 1'b1;
                    word_cnt_d  = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        if (issue) begin
            rk_valid_d = 1'b1;
            rk_data_d  = acc_data_i;
            rk_idx_d   = out_cnt_q;
            out_cnt_d  = out_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            round_q    <= '0;
            out_cnt_q  <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            round_q    <= round_d;
            out_cnt_q  <= out_cnt_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid_o = rk_valid_q;
    assign rk_data_o  = rk_data_q;
    assign rk_idx_o   = rk_idx_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
